// File: rtl/pp_accumulate16.sv
// pp_accumulate16: sequential shift-and-add accumulator forming P = A * B from
// the sixteen shifted multiplicand copies, retiring BITS_PER_CYCLE multiplier
// bits per RUN cycle.
// Ports:
//   i_clk            rising-edge clock
//   i_rst_n          asynchronous active-low reset
//   i_start          request a new multiplication (accepted in IDLE or FIN)
//   i_b[15:0]        multiplier, latched on an accepted start
//   i_s0..i_sf[31:0] shifted multiplicand copies, i_sN = A << N
//   o_p[31:0]        product, held until the next result
//   o_busy           high while in RUN
//   o_done           one-cycle pulse, o_p valid while high
module pp_accumulate16 #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_b,
    input  logic [31:0] i_s0,
    input  logic [31:0] i_s1,
    input  logic [31:0] i_s2,
    input  logic [31:0] i_s3,
    input  logic [31:0] i_s4,
    input  logic [31:0] i_s5,
    input  logic [31:0] i_s6,
    input  logic [31:0] i_s7,
    input  logic [31:0] i_s8,
    input  logic [31:0] i_s9,
    input  logic [31:0] i_sa,
    input  logic [31:0] i_sb,
    input  logic [31:0] i_sc,
    input  logic [31:0] i_sd,
    input  logic [31:0] i_se,
    input  logic [31:0] i_sf,
    output logic [31:0] o_p,
    output logic        o_busy,
    output logic        o_done
);
    localparam int K = BITS_PER_CYCLE;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
    // Index advance and the index of the final step; idx never wraps because
    // K divides 16, so the K=16 step value of zero is never used.
    localparam logic [3:0] STEP = 4'(K);
    localparam logic [3:0] LAST = 4'(16 - K);

    if (!(K == 1 || K == 2 || K == 4 || K == 8 || K == 16)) begin : g_bad_k
        $error("pp_accumulate16: BITS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    logic [1:0]  r_state;
    logic [15:0] r_breg;
    logic [3:0]  r_idx;
    logic [31:0] r_acc;
    logic [31:0] r_p;
    logic [31:0] w_s [16];
    logic [31:0] w_sum;

    assign w_s = '{i_s0, i_s1, i_s2, i_s3, i_s4, i_s5, i_s6, i_s7,
                   i_s8, i_s9, i_sa, i_sb, i_sc, i_sd, i_se, i_sf};

    // Sum of the selected shifted copies for the K bits retired this cycle.
    always_comb begin
        w_sum = '0;
        for (int j = 0; j < K; j++)
            w_sum = w_sum + (r_breg[r_idx + 4'(j)] ? w_s[r_idx + 4'(j)] : 32'd0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_breg  <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_p     <= '0;
        end else if (r_state == RUN) begin
            if (r_idx == LAST) begin
                r_p     <= r_acc + w_sum;
                r_state <= FIN;
            end else begin
                r_acc <= r_acc + w_sum;
                r_idx <= r_idx + STEP;
            end
        end else if (i_start) begin
            r_breg  <= i_b;
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= RUN;
        end else begin
            r_state <= IDLE;
        end
    end

    assign o_p    = r_p;
    assign o_busy = (r_state == RUN);
    assign o_done = (r_state == FIN);
endmodule

// File: tb/tb_pp_accumulate16.sv
// tb_pp_accumulate16: directed and random checks of pp_accumulate16 for every
// legal BITS_PER_CYCLE, with one instance per K sharing the same stimulus.
module tb_pp_accumulate16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [31:0] s [16];
    logic [31:0] p [5];
    logic        busy [5];
    logic        done [5];
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;
    vec_t vecs [10];

    always #5 clk = ~clk;

    always_comb
        for (int i = 0; i < 16; i++) s[i] = {16'b0, a} << i;

    for (genvar g = 0; g < 5; g++) begin : gd
        pp_accumulate16 #(.BITS_PER_CYCLE(1 << g)) u_dut (
            .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_b(b),
            .i_s0(s[0]), .i_s1(s[1]), .i_s2(s[2]), .i_s3(s[3]),
            .i_s4(s[4]), .i_s5(s[5]), .i_s6(s[6]), .i_s7(s[7]),
            .i_s8(s[8]), .i_s9(s[9]), .i_sa(s[10]), .i_sb(s[11]),
            .i_sc(s[12]), .i_sd(s[13]), .i_se(s[14]), .i_sf(s[15]),
            .o_p(p[g]), .o_busy(busy[g]), .o_done(done[g])
        );
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s K=%0d got=%h want=%h", nm, 1 << k, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string nm);
        for (int k = 0; k < 5; k++) begin
            chk({nm, "_p"}, k, p[k], 32'd0);
            chk({nm, "_busy"}, k, 32'(busy[k]), 32'd0);
            chk({nm, "_done"}, k, 32'(done[k]), 32'd0);
        end
    endtask

    // Starts one op on all instances and checks latency, product, BUSY length,
    // single DONE pulse and BUSY/DONE exclusivity for each K.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] ep);
        int dc [5];
        int nd [5];
        int nb [5];
        int ov [5];
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            dc[k] = -1;
            nd[k] = 0;
            nb[k] = busy[k] ? 1 : 0;
            ov[k] = (busy[k] && done[k]) ? 1 : 0;
        end
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 5; k++) begin
                if (done[k]) begin
                    nd[k]++;
                    if (dc[k] < 0) dc[k] = c;
                end
                if (busy[k]) nb[k]++;
                if (busy[k] && done[k]) ov[k]++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            chk("latency", k, 32'(dc[k]), 32'(16 >> k));
            chk("product", k, p[k], ep);
            chk("busy_cycles", k, 32'(nb[k]), 32'(16 >> k));
            chk("done_pulses", k, 32'(nd[k]), 32'd1);
            chk("busy_done_overlap", k, 32'(ov[k]), 32'd0);
        end
    endtask

    initial begin
        int dc;
        int nd;
        logic [15:0] ra;
        logic [15:0] rb;
        vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{16'h1234, 16'h0000, 32'h00000000};
        vecs[3] = '{16'h00FF, 16'h0101, 32'h0000FFFF};
        vecs[4] = '{16'h0002, 16'h0003, 32'h00000006};
        vecs[5] = '{16'h0010, 16'h0010, 32'h00000100};
        vecs[6] = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[7] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
        vecs[8] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
        vecs[9] = '{16'hABCD, 16'h0002, 32'h0001579A};

        #1;
        chk_zero_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_zero_outputs("idle_after_reset");

        for (int v = 0; v < 10; v++) run_op(vecs[v].a, vecs[v].b, vecs[v].p);

        // START and B disturbed mid-run, then a back-to-back START in the DONE cycle.
        a = 16'h0002;
        b = 16'h0003;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dc = -1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (done[0] && dc < 0) dc = c;
            start = (c == 4 || c == 16);
            b = (c == 4) ? 16'hFFFF : (c == 16) ? 16'h0004 : b;
        end
        chk("restart_ignored_latency", 0, 32'(dc), 32'd16);
        chk("restart_ignored_product", 0, p[0], 32'h00000006);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", 0, 32'(busy[0]), 32'd1);
        dc = -1;
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk); #1;
            if (done[0] && dc < 0) dc = c;
        end
        chk("b2b_latency", 0, 32'(dc), 32'd16);
        chk("b2b_product", 0, p[0], 32'h00000008);
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a K=1 operation.
        a = 16'h0077;
        b = 16'h0033;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done[0]) nd++;
        end
        chk("abort_no_done", 0, 32'(nd), 32'd0);
        chk("abort_p_held", 0, p[0], 32'd0);
        run_op(16'h0010, 16'h0010, 32'h00000100);

        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(ra, rb, 32'(ra) * 32'(rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pp_accumulate16.md
# pp_accumulate16

Sequential partial-product accumulator that consumes the sixteen shifted copies S0..SF of a 16-bit multiplicand produced by the shift stage and forms the 32-bit product P = A × B. It is the stage directly downstream of the shifter in the 16×16 multiplier datapath. Each cycle it selects the shifted copies that correspond to K multiplier bits and adds them into a running accumulator. It signals completion with a one-cycle DONE pulse.

## Interface
- BITS_PER_CYCLE, default 1: multiplier bits retired per RUN cycle (K). Legal values are 1, 2, 4, 8 and 16. Any other value is an elaboration error.
- CLK  input  1  rising-edge clock. This is the only clock.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  request a new multiplication. Sampled on the rising edge of CLK.
- B  input  16  multiplier. Latched on an accepted START.
- S0..SF  input  32 each  shifted multiplicand copies; SI = A << I with A zero-extended to 32 bits.
- P  output  32  product. Holds the last result until the next result is written.
- BUSY  output  1  high while an operation is in progress (RUN state).
- DONE  output  1  one-cycle pulse; P is valid while DONE is high.

## Operation
- Fixed decision: one clock; reset is asynchronous and active-low.
- Internal state:
  - state: IDLE, RUN or FIN.
  - breg[15:0]: latched multiplier.
  - idx: 0..15, in steps of K.
  - acc[31:0]: running sum.
- RST_N low, applied immediately and regardless of CLK: state=IDLE, P=0, BUSY=0, DONE=0, acc=0, breg=0, idx=0.
- IDLE or FIN with START=1:
  - breg<=B, acc<=0, idx<=0.
  - Go to RUN.
- IDLE with START=0: stay in IDLE.
- FIN with START=0: go to IDLE.
- RUN, each edge:
  - sum = Σ over j=0..K-1 of (breg[idx+j] ? S(idx+j) : 0).
  - If idx+K < 16: acc<=acc+sum, idx<=idx+K, stay in RUN.
  - If idx+K = 16 (last step): P<=acc+sum, go to FIN.
- All additions are 32 bits, truncated modulo 2^32. The product of two 16-bit operands is at most 0xFFFE0001, so no true overflow occurs.
- START is ignored in RUN. breg and acc are not disturbed.
- S0..SF are read combinationally in every RUN cycle and are not captured. Upstream must hold A constant from the START edge until DONE. The bench enforces this rule. The block does not check it.
- B is only read on the START edge. Changes to B afterwards have no effect.
- P changes only on the last RUN edge or on reset.

## Timing
- N = 16/K RUN cycles.
- START sampled at edge t:
  - BUSY=1 from edge t through edge t+N.
  - At edge t+N: P updated, DONE=1, BUSY=0.
  - At edge t+N+1: DONE=0 (or a new op starts if START=1).
- Latency from START to DONE is N cycles: 16 for K=1, 4 for K=4, 1 for K=16.
- Back-to-back operation: START high during the DONE cycle is accepted. Throughput is one result every N+1 cycles.
- Latency is independent of the operand values. A zero B still takes N cycles.
- Reset asserted mid-RUN:
  - Outputs return to their reset values immediately.
  - No DONE is produced for the aborted operation.
  - After RST_N rises, the first START begins a clean operation.
- BUSY and DONE are never high in the same cycle.

## Test plan
- K=1, A=0x0003, B=0x0005, START pulse → DONE 16 cycles later with P=0x0000000F; BUSY high for exactly those 16 cycles.
- K=1, A=0xFFFF, B=0xFFFF → P=0xFFFE0001. Also A=0x1234, B=0x0000 → P=0 with DONE still at 16 cycles.
- K=4, A=0x00FF, B=0x0101 → DONE after 4 cycles, P=0x0000FFFF. K=16, same operands → DONE after 1 cycle, P=0x0000FFFF.
- START re-pulsed and B changed to 0xFFFF at cycle 5 of a K=1 op with A=0x0002, B=0x0003 → both ignored; P=0x00000006 at cycle 16. Then START in the DONE cycle with B=0x0004 → next P=0x00000008 after 16 more cycles.
- RST_N pulsed low at cycle 7 of a K=1 op → P=0, BUSY=0, DONE=0 immediately, with no DONE afterwards. Then A=0x0010, B=0x0010 → P=0x00000100.
- Random sweep: 1000 random A/B pairs for each legal K → P equals A×B and the DONE spacing equals 16/K on every operation.
